// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared opcodes, FSM state encoding and sizing helpers for alu_seq.
// Optional feature macro used by this block: ALU_SEQ_DIV_EN (builds the iterative divider).
package alu_seq_pkg;

    localparam int unsigned OPCODE_W = 5;

    localparam logic [OPCODE_W-1:0] OP_ADD = 5'b00000;
    localparam logic [OPCODE_W-1:0] OP_SUB = 5'b00001;
    localparam logic [OPCODE_W-1:0] OP_AND = 5'b00010;
    localparam logic [OPCODE_W-1:0] OP_OR  = 5'b00011;
    localparam logic [OPCODE_W-1:0] OP_SLL = 5'b00100;
    localparam logic [OPCODE_W-1:0] OP_SRA = 5'b00101;
    localparam logic [OPCODE_W-1:0] OP_MUL = 5'b00110;
    localparam logic [OPCODE_W-1:0] OP_DIV = 5'b00111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 32;

    // Counter must hold the value WIDTH, hence one bit more than log2.
    function automatic int unsigned iter_cnt_w(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

    localparam int unsigned ITER_CNT_W = iter_cnt_w(DEFAULT_WIDTH);

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/result bundle between the execute stage and alu_seq.
// Request: ctrl_start, ctrl_ALUopcode, ctrl_shiftamt, data_operandA, data_operandB.
// Response: ready, data_result, data_resultRDY, isNotEqual, isLessThan, overflow, data_exception.
// slave = ALU side, master = issuing side.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 32
);
    import alu_seq_pkg::*;

    localparam int unsigned SHAMT_W = $clog2(WIDTH);

    logic                ctrl_start;
    logic [OPCODE_W-1:0] ctrl_ALUopcode;
    logic [SHAMT_W-1:0]  ctrl_shiftamt;
    logic [WIDTH-1:0]    data_operandA;
    logic [WIDTH-1:0]    data_operandB;
    logic                ready;
    logic [WIDTH-1:0]    data_result;
    logic                data_resultRDY;
    logic                isNotEqual;
    logic                isLessThan;
    logic                overflow;
    logic                data_exception;

    modport slave (
        input  ctrl_start, ctrl_ALUopcode, ctrl_shiftamt, data_operandA, data_operandB,
        output ready, data_result, data_resultRDY, isNotEqual, isLessThan, overflow,
               data_exception
    );

    modport master (
        output ctrl_start, ctrl_ALUopcode, ctrl_shiftamt, data_operandA, data_operandB,
        input  ready, data_result, data_resultRDY, isNotEqual, isLessThan, overflow,
               data_exception
    );

endinterface

// File: rtl/alu_seq_iter.sv
// alu_seq_iter: iterative signed multiply (shift-add) and, with ALU_SEQ_DIV_EN,
// signed restoring divide. Works on magnitudes and fixes the sign at the end.
// Ports: clock, reset (async, active-high); start loads operands; mode 0=MUL 1=DIV;
// operand_a/operand_b; done is a registered one-cycle flag raised after the last
// iteration; result_c/exception_c are valid while done=1.
module alu_seq_iter
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             done,
    output logic [WIDTH-1:0] result_c,
    output logic             exception_c
);

    localparam int unsigned CNT_W  = iter_cnt_w(WIDTH);
    localparam int unsigned PROD_W = 2 * WIDTH;

    logic             busy;
    logic [CNT_W-1:0] cnt;
    logic             mode_q;
    logic             neg_q;
    logic [WIDTH-1:0] mag_a_c;
    logic [WIDTH-1:0] mag_b_c;

    logic [PROD_W-1:0] acc;
    logic [PROD_W-1:0] mcand;
    logic [WIDTH-1:0]  mplier;
    logic [PROD_W-1:0] prod_c;

    // Operand magnitudes; |MIN| is exactly representable as unsigned.
    always_comb begin
        mag_a_c = operand_a[WIDTH-1] ? (WIDTH'(0) - operand_a) : operand_a;
        mag_b_c = operand_b[WIDTH-1] ? (WIDTH'(0) - operand_b) : operand_b;
    end

    // Iteration control: WIDTH iterations, done raised on the last one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            cnt    <= '0;
            mode_q <= 1'b0;
            neg_q  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                busy   <= 1'b1;
                cnt    <= '0;
                mode_q <= mode;
                neg_q  <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
            end else if (busy) begin
                cnt <= cnt + CNT_W'(1);
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    // Shift-add multiply on magnitudes, one multiplier bit per cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= {WIDTH'(0), mag_a_c};
            mplier <= mag_b_c;
        end else if (busy && !mode_q) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

`ifdef ALU_SEQ_DIV_EN
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic             div_zero;
    logic             div_ovf;
    logic [WIDTH:0]   rem_sh_c;
    logic [WIDTH:0]   rem_sub_c;
    logic [WIDTH-1:0] quo_c;

    // Trial subtract; remainder < divisor keeps the borrow in bit WIDTH.
    always_comb begin
        rem_sh_c  = {rem, dvd[WIDTH-1]};
        rem_sub_c = rem_sh_c - {1'b0, dvs};
        quo_c     = neg_q ? (WIDTH'(0) - dvd) : dvd;
    end

    // Restoring divide: dividend shifts out the top, quotient bits shift in the bottom.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rem      <= '0;
            dvd      <= '0;
            dvs      <= '0;
            div_zero <= 1'b0;
            div_ovf  <= 1'b0;
        end else if (start) begin
            rem      <= '0;
            dvd      <= mag_a_c;
            dvs      <= mag_b_c;
            div_zero <= (operand_b == '0);
            div_ovf  <= (operand_a == {1'b1, {(WIDTH-1){1'b0}}}) && (&operand_b);
        end else if (busy && mode_q) begin
            if (!rem_sub_c[WIDTH]) begin
                rem <= rem_sub_c[WIDTH-1:0];
                dvd <= {dvd[WIDTH-2:0], 1'b1};
            end else begin
                rem <= rem_sh_c[WIDTH-1:0];
                dvd <= {dvd[WIDTH-2:0], 1'b0};
            end
        end
    end
`endif

    // Final sign fix-up and error detection.
    always_comb begin
        prod_c      = neg_q ? (PROD_W'(0) - acc) : acc;
        result_c    = prod_c[WIDTH-1:0];
        // Product fits when the top WIDTH+1 bits are all copies of the sign.
        exception_c = !((&prod_c[PROD_W-1:WIDTH-1]) || !(|prod_c[PROD_W-1:WIDTH-1]));
`ifdef ALU_SEQ_DIV_EN
        if (mode_q) begin
            result_c    = div_zero ? '0 : quo_c;
            exception_c = div_zero || div_ovf;
        end
`endif
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered execute-stage ALU with start/ready handshake.
// Single-cycle ops finish one edge after accept; MUL (and DIV when ALU_SEQ_DIV_EN
// is defined) iterate in alu_seq_iter and finish WIDTH+1 edges after accept.
// Without ALU_SEQ_DIV_EN, DIV finishes in one cycle with result 0 and data_exception=1.
// Ports: clock, reset (async, active-high), bus (alu_seq_if.slave): request fields
// in, ready (combinational), registered result/flags and one-cycle data_resultRDY out.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic     clock,
    input  logic     reset,
    alu_seq_if.slave bus
);

    localparam int unsigned SHAMT_W = $clog2(WIDTH);

    state_t state;
    state_t state_next;

    logic ready_c;
    logic accept_c;
    logic iter_start_c;
    logic op_is_mul_c;
    logic op_is_div_c;

    logic                pend_valid;
    logic [OPCODE_W-1:0] pend_op;
    logic [WIDTH-1:0]    pend_a;
    logic [WIDTH-1:0]    pend_b;
    logic [SHAMT_W-1:0]  pend_shamt;

    logic             iter_done;
    logic [WIDTH-1:0] iter_result;
    logic             iter_exception;

    logic [WIDTH-1:0] diff_c;
    logic [WIDTH-1:0] sum_c;
    logic             sub_ovf_c;
    logic             add_ovf_c;
    logic             cmp_en_c;
    logic [WIDTH-1:0] sc_result_c;
    logic             sc_ovf_c;
    logic             sc_exc_c;
    logic             sc_ne_c;
    logic             sc_lt_c;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: a new iterative op may start on the completion edge.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (iter_start_c) begin
                    state_next = op_is_div_c ? DIV : MUL;
                end
            end
            MUL, DIV: begin
                if (iter_done) begin
                    state_next = IDLE;
                    if (iter_start_c) begin
                        state_next = op_is_div_c ? DIV : MUL;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs and accept decode.
    always_comb begin
        ready_c      = 1'b0;
        op_is_mul_c  = (bus.ctrl_ALUopcode == OP_MUL);
        op_is_div_c  = (bus.ctrl_ALUopcode == OP_DIV);
        if (state == IDLE || iter_done) begin
            ready_c = 1'b1;
        end
        accept_c = bus.ctrl_start && ready_c;
`ifdef ALU_SEQ_DIV_EN
        iter_start_c = accept_c && (op_is_mul_c || op_is_div_c);
`else
        iter_start_c = accept_c && op_is_mul_c;
`endif
    end

    assign bus.ready = ready_c;

    // Accepted single-cycle op waits here for one cycle before its result is registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend_op    <= OP_ADD;
            pend_a     <= '0;
            pend_b     <= '0;
            pend_shamt <= '0;
        end else begin
            pend_valid <= accept_c && !iter_start_c;
            if (accept_c) begin
                pend_op    <= bus.ctrl_ALUopcode;
                pend_a     <= bus.data_operandA;
                pend_b     <= bus.data_operandB;
                pend_shamt <= bus.ctrl_shiftamt;
            end
        end
    end

    // Single-cycle datapath; compare flags come from A-B with overflow correction.
    always_comb begin
        diff_c      = pend_a - pend_b;
        sum_c       = pend_a + pend_b;
        sub_ovf_c   = (pend_a[WIDTH-1] != pend_b[WIDTH-1]) && (diff_c[WIDTH-1] != pend_a[WIDTH-1]);
        add_ovf_c   = (pend_a[WIDTH-1] == pend_b[WIDTH-1]) && (sum_c[WIDTH-1] != pend_a[WIDTH-1]);
        sc_result_c = '0;
        sc_ovf_c    = 1'b0;
        sc_exc_c    = 1'b0;
        cmp_en_c    = 1'b1;
        case (pend_op)
            OP_ADD: begin
                sc_result_c = sum_c;
                sc_ovf_c    = add_ovf_c;
            end
            OP_SUB: begin
                sc_result_c = diff_c;
                sc_ovf_c    = sub_ovf_c;
            end
            OP_AND: sc_result_c = pend_a & pend_b;
            OP_OR:  sc_result_c = pend_a | pend_b;
            OP_SLL: sc_result_c = pend_a << pend_shamt;
            OP_SRA: sc_result_c = $signed(pend_a) >>> pend_shamt;
`ifndef ALU_SEQ_DIV_EN
            OP_DIV: begin
                sc_exc_c = 1'b1;
                cmp_en_c = 1'b0;
            end
`endif
            default: cmp_en_c = 1'b0;
        endcase
        sc_ne_c = cmp_en_c && (pend_a != pend_b);
        sc_lt_c = cmp_en_c && (diff_c[WIDTH-1] ^ sub_ovf_c);
    end

    // Result registers hold between completions; only data_resultRDY pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.data_result    <= '0;
            bus.data_resultRDY <= 1'b0;
            bus.isNotEqual     <= 1'b0;
            bus.isLessThan     <= 1'b0;
            bus.overflow       <= 1'b0;
            bus.data_exception <= 1'b0;
        end else begin
            bus.data_resultRDY <= 1'b0;
            if (iter_done) begin
                bus.data_result    <= iter_result;
                bus.data_resultRDY <= 1'b1;
                bus.isNotEqual     <= 1'b0;
                bus.isLessThan     <= 1'b0;
                bus.overflow       <= 1'b0;
                bus.data_exception <= iter_exception;
            end else if (pend_valid) begin
                bus.data_result    <= sc_result_c;
                bus.data_resultRDY <= 1'b1;
                bus.isNotEqual     <= sc_ne_c;
                bus.isLessThan     <= sc_lt_c;
                bus.overflow       <= sc_ovf_c;
                bus.data_exception <= sc_exc_c;
            end
        end
    end

    alu_seq_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clock      (clock),
        .reset      (reset),
        .start      (iter_start_c),
        .mode       (op_is_div_c),
        .operand_a  (bus.data_operandA),
        .operand_b  (bus.data_operandB),
        .done       (iter_done),
        .result_c   (iter_result),
        .exception_c(iter_exception)
    );

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (WIDTH=32).
// Covers ALU_SEQ_DIV_EN defined and undefined builds.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int unsigned WIDTH = 32;

    logic clock = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    int   lat;
    int   busy_n;
    int   rdy_n;

    alu_seq_if #(.WIDTH(WIDTH)) bus ();

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
        bus.ctrl_start     = 1'b1;
        bus.ctrl_ALUopcode = op;
        bus.data_operandA  = a;
        bus.data_operandB  = b;
        bus.ctrl_shiftamt  = sh;
    endtask

    task automatic check_flags(input string tag, input logic [31:0] res, input logic ne,
                               input logic lt, input logic ovf, input logic exc);
        check({tag, ".rdy"},    32'(bus.data_resultRDY), 32'd1);
        check({tag, ".result"}, bus.data_result, res);
        check({tag, ".ne"},     32'(bus.isNotEqual), 32'(ne));
        check({tag, ".lt"},     32'(bus.isLessThan), 32'(lt));
        check({tag, ".ovf"},    32'(bus.overflow), 32'(ovf));
        check({tag, ".exc"},    32'(bus.data_exception), 32'(exc));
    endtask

    // Single-cycle op: accept at edge N, result at edge N+1.
    task automatic sc_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh, input logic [31:0] res,
                         input logic ne, input logic lt, input logic ovf, input logic exc);
        drive(op, a, b, sh);
        tick();
        bus.ctrl_start = 1'b0;
        check({tag, ".ready"}, 32'(bus.ready), 32'd1);
        tick();
        check_flags(tag, res, ne, lt, ovf, exc);
    endtask

    // Iterative op; at step inject an ADD 2+3 is driven (ignored while busy,
    // accepted if it lands in the final cycle).
    task automatic it_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int inject, input logic [31:0] res,
                         input logic exc);
        drive(op, a, b, 5'd0);
        tick();
        bus.ctrl_start = 1'b0;
        lat    = 0;
        busy_n = 0;
        for (int t = 1; t <= 40; t++) begin
            if (bus.ready === 1'b0) busy_n++;
            if (t == inject) drive(OP_ADD, 32'd2, 32'd3, 5'd0);
            else bus.ctrl_start = 1'b0;
            tick();
            if (bus.data_resultRDY === 1'b1) begin
                lat = t;
                break;
            end
        end
        bus.ctrl_start = 1'b0;
        check({tag, ".latency"}, 32'(lat), 32'(WIDTH + 1));
        check({tag, ".busy_cycles"}, 32'(busy_n), 32'(WIDTH));
        check_flags(tag, res, 1'b0, 1'b0, 1'b0, exc);
        tick();
        if (inject == WIDTH + 1) begin
            check({tag, ".chained_rdy"}, 32'(bus.data_resultRDY), 32'd1);
            check({tag, ".chained_result"}, bus.data_result, 32'd5);
        end else begin
            check({tag, ".no_extra_rdy"}, 32'(bus.data_resultRDY), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset              = 1'b1;
        bus.ctrl_start     = 1'b0;
        bus.ctrl_ALUopcode = OP_ADD;
        bus.ctrl_shiftamt  = '0;
        bus.data_operandA  = '0;
        bus.data_operandB  = '0;
        tick();
        tick();
        check("reset.result", bus.data_result, 32'd0);
        check("reset.rdy",    32'(bus.data_resultRDY), 32'd0);
        check("reset.ne",     32'(bus.isNotEqual), 32'd0);
        check("reset.lt",     32'(bus.isLessThan), 32'd0);
        check("reset.ovf",    32'(bus.overflow), 32'd0);
        check("reset.exc",    32'(bus.data_exception), 32'd0);
        check("reset.ready",  32'(bus.ready), 32'd1);
        reset = 1'b0;
        tick();

        sc_op("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 32'h8000_0000,
              1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        check("add_ovf.pulse_end", 32'(bus.data_resultRDY), 32'd0);
        check("add_ovf.hold", bus.data_result, 32'h8000_0000);

        // SUB then AND back to back.
        drive(OP_SUB, 32'd3, 32'd5, 5'd0);
        tick();
        drive(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0);
        tick();
        bus.ctrl_start = 1'b0;
        check_flags("sub_b2b", 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check_flags("and_b2b", 32'hF000_F000, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check("and_b2b.pulse_end", 32'(bus.data_resultRDY), 32'd0);

        sc_op("sll31", OP_SLL, 32'd1, 32'd1, 5'd31, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        sc_op("sra4",  OP_SRA, 32'h8000_0000, 32'd0, 5'd4, 32'hF800_0000, 1'b1, 1'b1, 1'b0, 1'b0);
        sc_op("or",    OP_OR,  32'h0000_000F, 32'h0000_00F0, 5'd0, 32'h0000_00FF,
              1'b1, 1'b1, 1'b0, 1'b0);
        sc_op("badop", 5'b01000, 32'd5, 32'd3, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        it_op("mul_neg", OP_MUL, 32'hFFFF_FFF9, 32'd6, 5, 32'hFFFF_FFD6, 1'b0);
        it_op("mul_big", OP_MUL, 32'h0001_0000, 32'h0001_0000, 0, 32'h0000_0000, 1'b1);
        sc_op("sub_ovf", OP_SUB, 32'h8000_0000, 32'd1, 5'd0, 32'h7FFF_FFFF,
              1'b1, 1'b1, 1'b1, 1'b0);
        it_op("mul_m1m1", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, WIDTH + 1, 32'h0000_0001, 1'b0);

`ifdef ALU_SEQ_DIV_EN
        it_op("div_neg",  OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFD, 1'b0);
        it_op("div_zero", OP_DIV, 32'd5, 32'd0, 0, 32'd0, 1'b1);
        it_op("div_ovf",  OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, 1'b1);
`else
        sc_op("div_off", OP_DIV, 32'd8, 32'd2, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

        // Reset in the middle of a MUL abandons it.
        drive(OP_MUL, 32'd3, 32'd4, 5'd0);
        tick();
        bus.ctrl_start = 1'b0;
        repeat (10) tick();
        check("mid_mul.busy", 32'(bus.ready), 32'd0);
        reset = 1'b1;
        #1;
        check("async_rst.ready",  32'(bus.ready), 32'd1);
        check("async_rst.result", bus.data_result, 32'd0);
        check("async_rst.rdy",    32'(bus.data_resultRDY), 32'd0);
        check("async_rst.exc",    32'(bus.data_exception), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        rdy_n = 0;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (bus.data_resultRDY !== 1'b0) rdy_n++;
        end
        check("abandoned.rdy_pulses", 32'(rdy_n), 32'd0);
        sc_op("add_after_rst", OP_ADD, 32'd2, 32'd2, 5'd0, 32'd4, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the combinational CPU ALU.
- Adds iterative signed multiply and divide, a start/ready handshake and a result-ready pulse.
- Sits in the execute stage. Stall logic holds the pipeline while ready=0.
- Single-cycle ops keep throughput of one per cycle.

Parameters:
- WIDTH, 32: operand/result width. Power of two, >=4.
- SHAMT_W, $clog2(WIDTH): shift-amount width (derived; do not override).

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- ctrl_start  in  1  operation request; accepted only when ready=1.
- ctrl_ALUopcode  in  5  operation select, sampled at accept.
- ctrl_shiftamt  in  SHAMT_W  shift amount for SLL/SRA, sampled at accept.
- data_operandA  in  WIDTH  operand A, sampled at accept.
- data_operandB  in  WIDTH  operand B, sampled at accept.
- ready  out  1  can accept ctrl_start this cycle.
- data_result  out  WIDTH  registered result.
- data_resultRDY  out  1  one-cycle pulse: result fields valid/updated.
- isNotEqual  out  1  A!=B (registered).
- isLessThan  out  1  signed A<B (registered).
- overflow  out  1  ADD/SUB signed overflow.
- data_exception  out  1  MUL/DIV error.

Behaviour:
- Opcodes:
  - 00000 ADD
  - 00001 SUB
  - 00010 AND
  - 00011 OR
  - 00100 SLL
  - 00101 SRA
  - 00110 MUL
  - 00111 DIV
  - Any other code completes in one cycle with result 0 and all flags 0.
- Reset (asynchronous): state=IDLE; data_result, data_resultRDY, isNotEqual, isLessThan, overflow, data_exception all 0. ready=1 immediately.
- Reset mid-operation abandons the operation with no RDY pulse.
- States: IDLE, MUL, DIV. ready = (state==IDLE) or final iteration cycle.
- Accept: ctrl_start & ready at edge N. ctrl_start while ready=0 is ignored, not queued.
- Single-cycle ops:
  - Results and flags are registered at edge N+1, with data_resultRDY=1 for that one cycle.
  - ready stays 1, so back-to-back issue is allowed.
- isNotEqual/isLessThan:
  - Computed from A-B with overflow correction (isLessThan = diff_msb XOR ovf), for all single-cycle ops.
  - Forced 0 on MUL/DIV completion.
- overflow: signed overflow for ADD/SUB; 0 otherwise.
- MUL (signed, shift-add, one bit per cycle):
  - IDLE->MUL at accept; WIDTH iterations.
  - Completes at edge N+WIDTH+1 with RDY pulse; ready=1 in that final cycle, so a new start can be accepted on the completion edge.
  - Result = low WIDTH bits of the 2*WIDTH product.
  - data_exception=1 iff the full product does not sign-fit WIDTH bits.
- DIV (signed restoring, quotient truncates toward zero):
  - Same timing as MUL.
  - B==0: result 0, data_exception=1.
  - MIN/-1: result MIN, data_exception=1.
  - Remainder discarded.
- data_exception is 0 on every non-MUL/DIV completion.
- Outputs hold their values between completions. Only data_resultRDY is a pulse.

Optional Feature:
- Macro: ALU_SEQ_DIV_EN.
- Defined: DIV implemented as above.
- Undefined:
  - No divider logic is built.
  - DIV completes in one cycle (edge N+1) with result 0, data_exception=1, RDY pulse.
  - The DIV state is unreachable.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode localparams (OP_ADD..OP_DIV);
  - state enum (IDLE/MUL/DIV);
  - ITER_CNT_W=$clog2(WIDTH)+1.
- One sub-module, alu_seq_iter: shift-add multiply / restoring divide datapath with iteration counter.
  - Inputs: start, mode, operands.
  - Outputs: done, result, exception.
- Single-cycle ops stay in alu_seq.

Test Plan:
- ADD 0x7FFFFFFF+0x00000001 -> at edge N+1: result 0x80000000, overflow=1, RDY pulse 1 cycle, ready held 1.
- SUB 3-5, then AND 0xF0F0F0F0&0xFF00FF00 issued next cycle -> edge N+1: 0xFFFFFFFE, isLessThan=1, isNotEqual=1. Edge N+2: 0xF000F000, isLessThan=1, isNotEqual=1.
- MUL -7*6 -> ready=0 for 32 cycles; RDY at edge N+33 with result 0xFFFFFFD6, exception 0. ADD issued during busy is ignored (no extra RDY).
- MUL 0x00010000*0x00010000 -> result 0x00000000, data_exception=1. MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001, exception 0.
- DIV -7/2 -> 0xFFFFFFFD. DIV 5/0 -> 0, exception=1. DIV 0x80000000/-1 -> 0x80000000, exception=1. With ALU_SEQ_DIV_EN undefined, DIV 8/2 -> edge N+1: result 0, exception=1.
- Reset asserted at cycle 10 of a MUL -> all outputs 0 and ready=1 asynchronously, no RDY pulse. ADD 2+2 after deassert -> 4 at edge N+1.
